i2c_wb_seq: RTL and testbench
=============================

Name: i2c_wb_seq

Overview:
Register-access sequencer sitting directly upstream of the I2C master core. It accepts one simple "read/write device register" request at a time and drives the core's 8-bit Wishbone slave port (PRER/CTR/TXR/RXR/CR/SR) through the full start/address/data/stop command sequence. It polls status, reports NACK, arbitration-lost and timeout, and returns read data. This lets system logic use I2C peripherals without a CPU.

Parameters:
PRESCALE, 16'd99, value written to PRER at init (SCL = clk/(5*(PRESCALE+1))).
POLL_MAX, 16'd4095, maximum SR reads per wait before declaring timeout.

Ports:
wb_clk_i  in  1  single clock, shared with the I2C core
wb_rst_i  in  1  reset; synchronous, active-high
req_valid  in  1  request strobe
req_ready  out  1  sequencer idle and initialised; accepts request
req_rw  in  1  1 = read, 0 = write
req_dev  in  7  7-bit I2C device address
req_reg  in  8  register/sub-address byte
req_wdata  in  8  write data (ignored on read)
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  8  read data; 0 for writes and errors
rsp_err  out  2  00 ok, 01 NACK, 10 arbitration lost, 11 timeout
busy  out  1  transaction or init in progress
wbm_cyc_o  out  1  Wishbone cycle to core
wbm_stb_o  out  1  Wishbone strobe to core
wbm_we_o  out  1  Wishbone write enable
wbm_adr_o  out  3  core register address
wbm_dat_o  out  8  write data to core
wbm_dat_i  in  8  read data from core
wbm_ack_i  in  1  core acknowledge (registered, one cycle)

Behaviour:
- Reset values: all outputs 0, except busy = 1. Init begins on the first cycle after wb_rst_i deasserts.
- Bus access: drive cyc/stb/adr/we/dat together and hold them until wbm_ack_i. Deassert cyc/stb in the cycle after ack. There is at least one idle cycle between accesses. Read data is sampled on the ack cycle. An ack received while stb is low is ignored.
- Init: write adr0 = PRESCALE[7:0], then adr1 = PRESCALE[15:8], then adr2 = 0x80 (core enable). After that, go to IDLE with req_ready = 1 and busy = 0.
- Request acceptance: a request is accepted when req_valid & req_ready. All request fields are latched at acceptance. req_ready drops the following cycle.
- Byte step: write TXR (adr3), then write CR (adr4), then WAIT_TIP.
  - WAIT_TIP reads SR (adr4) repeatedly until SR[1] (TIP) = 0.
  - Then, in priority order:
    - SR[5] (AL) = 1 → rsp_err = 10; go to IDLE; no STOP.
    - SR[7] (RXACK) = 1 → rsp_err = 01; go to STOP.
- Write sequence:
  - TXR = {dev,0}, CR = 0x91 (STA|WR|IACK)
  - TXR = reg, CR = 0x11
  - TXR = wdata, CR = 0x11
  - STOP
- Read sequence:
  - TXR = {dev,0}, CR = 0x91
  - TXR = reg, CR = 0x11
  - TXR = {dev,1}, CR = 0x91 (repeated start)
  - CR = 0x29 (RD|NACK|IACK), then WAIT_TIP with no RXACK check
  - read RXR (adr3) into rsp_rdata
  - STOP
- STOP: write CR = 0x41, then poll SR until SR[6] (busy) = 0. Then pulse rsp_valid for one cycle and return to IDLE.
- Timeout:
  - The poll counter clears at every wait entry and increments per SR read.
  - When the POLL_MAX-th read still fails the wait condition: write CTR = 0x00, then CTR = 0x80, then respond rsp_err = 11.
  - A timeout inside STOP also yields 11, overriding a pending 01.
- Responses:
  - rsp_rdata/rsp_err are valid only with rsp_valid and hold until the next response.
  - An error response on a read forces rsp_rdata = 0.
- Reset mid-operation: on the next edge cyc/stb = 0, no rsp_valid, latched request is discarded, init restarts.
- The request stays pending while not ready; a req_valid held across completion is accepted in the first IDLE cycle.

Decomposition:
- Package i2c_seq_pkg holds:
  - core register addresses: PRER_LO 0, PRER_HI 1, CTR 2, TXR/RXR 3, CR/SR 4
  - CR command constants and SR bit indices
  - rsp_err codes
  - the state enumeration: INIT_*, IDLE, TX_TXR, TX_CR, WAIT_TIP, RD_RXR, STOP_CR, WAIT_BUSY, TO_DIS, TO_EN, RESP
- Sub-module i2c_wb_seq_bus: a single-access Wishbone master with a start/write/adr/data in, done/rdata out handshake.
- The top-level FSM sequences steps through it.

Test Plan:
1. Release reset with PRESCALE = 99 → core sees writes adr0 = 0x63, adr1 = 0x00, adr2 = 0x80 in order; req_ready rises after the third ack.
2. Write request, dev 0x50 / reg 0x12 / data 0xA5, ACKing slave model → slave sees START, 0xA0, 0x12, 0xA5, STOP; rsp_valid with rsp_err = 00, rsp_rdata = 0x00.
3. Read request, dev 0x50 / reg 0x34, slave returns 0x5C → slave sees 0xA0, 0x34, repeated START, 0xA1, master NACK, STOP; rsp_rdata = 0x5C, rsp_err = 00.
4. Write to absent dev 0x3A → first poll shows RXACK = 1; CR = 0x41 issued; no further TXR writes; rsp_err = 01.
5. SR model with TIP stuck at 1 and POLL_MAX = 8 → exactly 8 SR reads, then CTR writes 0x00 and 0x80; rsp_err = 11.
6. Assert wb_rst_i for one cycle during the read's data phase with cyc high → cyc/stb = 0 the next cycle, no rsp_valid, init sequence repeats.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared constants and types for the I2C register-access sequencer:
// core register map, command/status encodings, response codes and FSM states.
package i2c_seq_pkg;

  localparam logic [2:0] ADR_PRER_LO = 3'd0;
  localparam logic [2:0] ADR_PRER_HI = 3'd1;
  localparam logic [2:0] ADR_CTR     = 3'd2;
  localparam logic [2:0] ADR_TXR     = 3'd3;
  localparam logic [2:0] ADR_RXR     = 3'd3;
  localparam logic [2:0] ADR_CR      = 3'd4;
  localparam logic [2:0] ADR_SR      = 3'd4;

  localparam logic [7:0] CTR_EN       = 8'h80;
  localparam logic [7:0] CTR_DIS      = 8'h00;
  localparam logic [7:0] CR_STA_WR    = 8'h91;
  localparam logic [7:0] CR_WR        = 8'h11;
  localparam logic [7:0] CR_RD_NACK   = 8'h29;
  localparam logic [7:0] CR_STO       = 8'h41;

  localparam int unsigned SR_RXACK = 7;
  localparam int unsigned SR_BUSY  = 6;
  localparam int unsigned SR_AL    = 5;
  localparam int unsigned SR_TIP   = 1;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_AL      = 2'b10,
    ERR_TIMEOUT = 2'b11
  } rsp_err_e;

  typedef enum logic [3:0] {
    INIT_PRER_LO,
    INIT_PRER_HI,
    INIT_CTR,
    IDLE,
    TX_TXR,
    TX_CR,
    WAIT_TIP,
    RD_RXR,
    STOP_CR,
    WAIT_BUSY,
    TO_DIS,
    TO_EN,
    RESP
  } state_e;

  // Step 2 of a read is the repeated-start address; step 3 only exists for reads.
  function automatic logic [7:0] cr_for_step(input logic rw, input logic [1:0] step);
    logic [7:0] cr;
    case (step)
      2'd0:    cr = CR_STA_WR;
      2'd1:    cr = CR_WR;
      2'd2:    cr = rw ? CR_STA_WR : CR_WR;
      default: cr = CR_RD_NACK;
    endcase
    return cr;
  endfunction

endpackage

// File: rtl/i2c_wb_seq_bus.sv
// Single-access Wishbone master: one start pulse launches one access, done
// pulses in the cycle after the ack with the sampled read data.
module i2c_wb_seq_bus
  import i2c_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       we_i,
  input  logic [2:0] adr_i,
  input  logic [7:0] dat_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       wbm_cyc_o,
  output logic       wbm_stb_o,
  output logic       wbm_we_o,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  input  logic       wbm_ack_i
);

  logic       cyc_q;
  logic       we_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q;
  logic [7:0] rdata_q;
  logic       done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cyc_q) begin
        if (wbm_ack_i) begin
          cyc_q   <= 1'b0;
          done_q  <= 1'b1;
          rdata_q <= wbm_dat_i;
        end
      end else if (start_i) begin
        // Acks arriving while idle are ignored by construction of this branch.
        cyc_q <= 1'b1;
        we_q  <= we_i;
        adr_q <= adr_i;
        dat_q <= dat_i;
      end
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign done_o    = done_q;
  assign rdata_o   = rdata_q;

endmodule

// File: rtl/i2c_wb_seq.sv
// Register-access sequencer driving the I2C master core's Wishbone port:
// init, start/address/data/stop sequencing, status polling and error reporting.
module i2c_wb_seq
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE = 16'd99,
  parameter logic [15:0] POLL_MAX = 16'd4095
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       busy,
  output logic       wbm_cyc_o,
  output logic       wbm_stb_o,
  output logic       wbm_we_o,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  input  logic       wbm_ack_i
);

  state_e     state_q;
  logic       acc_q;
  logic [1:0] step_q;
  logic [15:0] poll_q;
  rsp_err_e   err_q;
  logic [7:0] rd_q;
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;
  logic       start_q;
  logic       bwe_q;
  logic [2:0] badr_q;
  logic [7:0] bdat_q;
  logic       req_ready_q;
  logic       busy_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;
  logic [1:0] rsp_err_q;

  logic       bus_done;
  logic [7:0] bus_rdata;
  logic       uses_bus;
  logic       cmd_we;
  logic [2:0] cmd_adr;
  logic [7:0] cmd_dat;
  logic       poll_last;
  logic       done;

  i2c_wb_seq_bus u_bus (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .start_i   (start_q),
    .we_i      (bwe_q),
    .adr_i     (badr_q),
    .dat_i     (bdat_q),
    .done_o    (bus_done),
    .rdata_o   (bus_rdata),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  // Each bus-using state owns exactly one access, reissued while polling.
  always_comb begin
    uses_bus = 1'b1;
    cmd_we   = 1'b1;
    cmd_adr  = ADR_CR;
    cmd_dat  = '0;
    case (state_q)
      INIT_PRER_LO: begin cmd_adr = ADR_PRER_LO; cmd_dat = PRESCALE[7:0];  end
      INIT_PRER_HI: begin cmd_adr = ADR_PRER_HI; cmd_dat = PRESCALE[15:8]; end
      INIT_CTR:     begin cmd_adr = ADR_CTR;     cmd_dat = CTR_EN;         end
      TX_TXR: begin
        cmd_adr = ADR_TXR;
        case (step_q)
          2'd0:    cmd_dat = {dev_q, 1'b0};
          2'd1:    cmd_dat = reg_q;
          default: cmd_dat = rw_q ? {dev_q, 1'b1} : wdata_q;
        endcase
      end
      TX_CR:        begin cmd_adr = ADR_CR; cmd_dat = cr_for_step(rw_q, step_q); end
      WAIT_TIP,
      WAIT_BUSY:    begin cmd_we = 1'b0; cmd_adr = ADR_SR;  end
      RD_RXR:       begin cmd_we = 1'b0; cmd_adr = ADR_RXR; end
      STOP_CR:      begin cmd_adr = ADR_CR;  cmd_dat = CR_STO;  end
      TO_DIS:       begin cmd_adr = ADR_CTR; cmd_dat = CTR_DIS; end
      TO_EN:        begin cmd_adr = ADR_CTR; cmd_dat = CTR_EN;  end
      default:      uses_bus = 1'b0;
    endcase
  end

  assign done      = acc_q && bus_done;
  assign poll_last = (poll_q == POLL_MAX - 16'd1);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= INIT_PRER_LO;
      acc_q       <= 1'b0;
      step_q      <= '0;
      poll_q      <= '0;
      err_q       <= ERR_OK;
      rd_q        <= '0;
      rw_q        <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      start_q     <= 1'b0;
      bwe_q       <= 1'b0;
      badr_q      <= '0;
      bdat_q      <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= '0;
    end else begin
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      if (uses_bus) begin
        if (!acc_q) begin
          start_q <= 1'b1;
          acc_q   <= 1'b1;
          bwe_q   <= cmd_we;
          badr_q  <= cmd_adr;
          bdat_q  <= cmd_dat;
        end else if (bus_done) begin
          acc_q <= 1'b0;
        end
      end
      case (state_q)
        INIT_PRER_LO: if (done) state_q <= INIT_PRER_HI;
        INIT_PRER_HI: if (done) state_q <= INIT_CTR;
        INIT_CTR: if (done) begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        IDLE: if (req_valid && req_ready_q) begin
          rw_q        <= req_rw;
          dev_q       <= req_dev;
          reg_q       <= req_reg;
          wdata_q     <= req_wdata;
          step_q      <= '0;
          err_q       <= ERR_OK;
          rd_q        <= '0;
          req_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          state_q     <= TX_TXR;
        end
        TX_TXR: if (done) state_q <= TX_CR;
        TX_CR: if (done) begin
          poll_q  <= '0;
          state_q <= WAIT_TIP;
        end
        WAIT_TIP: if (done) begin
          if (bus_rdata[SR_TIP]) begin
            if (poll_last) state_q <= TO_DIS;
            else           poll_q  <= poll_q + 16'd1;
          end else if (bus_rdata[SR_AL]) begin
            err_q   <= ERR_AL;
            state_q <= RESP;
          end else if (rw_q && step_q == 2'd3) begin
            state_q <= RD_RXR;
          end else if (bus_rdata[SR_RXACK]) begin
            err_q   <= ERR_NACK;
            state_q <= STOP_CR;
          end else if (!rw_q && step_q == 2'd2) begin
            state_q <= STOP_CR;
          end else begin
            // The read-data step has no TXR byte, so it goes straight to CR.
            step_q  <= step_q + 2'd1;
            state_q <= (rw_q && step_q == 2'd2) ? TX_CR : TX_TXR;
          end
        end
        RD_RXR: if (done) begin
          rd_q    <= bus_rdata;
          state_q <= STOP_CR;
        end
        STOP_CR: if (done) begin
          poll_q  <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: if (done) begin
          if (bus_rdata[SR_BUSY]) begin
            if (poll_last) state_q <= TO_DIS;
            else           poll_q  <= poll_q + 16'd1;
          end else begin
            state_q <= RESP;
          end
        end
        TO_DIS: if (done) state_q <= TO_EN;
        TO_EN: if (done) begin
          err_q   <= ERR_TIMEOUT;
          state_q <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          rsp_rdata_q <= (rw_q && err_q == ERR_OK) ? rd_q : '0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= INIT_PRER_LO;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_i2c_wb_seq.sv
// Bench for i2c_wb_seq: register-level I2C core model with scoreboards for
// I2C bus events, control-register writes and responses.
module tb_i2c_wb_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev = '0;
  logic [7:0] req_reg = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, busy;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       cyc, stb, we;
  logic [2:0] adr;
  logic [7:0] dat_o;
  logic [7:0] dat_i = '0;
  logic       ack = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  i2c_wb_seq #(.PRESCALE(16'd99), .POLL_MAX(16'd8)) dut (
    .wb_clk_i (clk),      .wb_rst_i (rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev  (req_dev),  .req_reg  (req_reg),   .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy     (busy),
    .wbm_cyc_o(cyc),      .wbm_stb_o(stb),       .wbm_we_o(we),
    .wbm_adr_o(adr),      .wbm_dat_o(dat_o),     .wbm_dat_i(dat_i),
    .wbm_ack_i(ack)
  );

  // Core model state
  bit         m_tip_stuck = 0;
  bit         m_al = 0;
  int         m_tip_polls = 2;
  logic [6:0] m_dev = 7'h50;
  logic [7:0] m_rx = 8'h5C;
  logic [7:0] m_txr = '0;
  int         tip_left = 0;
  int         stop_left = 0;
  bit         m_busy = 0;
  bit         m_rxack = 0;
  int         sr_reads = 0;
  int         txr_cnt = 0;
  int         rsp_cnt = 0;
  bit         prev_rv = 0;

  logic [15:0] exp_ev[$];
  logic [10:0] exp_ctl[$];
  logic [9:0]  exp_rsp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sr_val();
    return {m_rxack, m_busy, m_al, 3'b000, (m_tip_stuck || tip_left > 0), 1'b0};
  endfunction

  task automatic log_ev(input logic [15:0] ev);
    if (exp_ev.size() == 0) chk("ev_unexpected", ev, 32'hFFFF);
    else                    chk("i2c_event", ev, exp_ev.pop_front());
  endtask

  task automatic cr_write(input logic [7:0] d);
    if (d[7]) begin log_ev(16'h0100); m_busy = 1; end
    if (d[4]) begin
      log_ev({8'h00, m_txr});
      m_rxack  = d[7] && (m_txr[7:1] != m_dev);
      tip_left = m_tip_polls;
    end
    if (d[5]) begin
      log_ev(16'h0300 | {15'b0, d[3]});
      m_rxack  = 0;
      tip_left = m_tip_polls;
    end
    if (d[6]) begin log_ev(16'h0200); stop_left = 1; end
  endtask

  // Registered one-cycle ack, read data taken from model state before side effects.
  always @(posedge clk) begin
    ack   <= cyc && stb && !ack;
    dat_i <= (adr == 3'd3) ? m_rx : (adr == 3'd4) ? sr_val() : 8'h00;
  end

  always @(negedge clk) begin
    if (ack && cyc && stb) begin
      if (we) begin
        if (adr <= 3'd2) begin
          if (exp_ctl.size() == 0) chk("ctl_unexpected", {adr, dat_o}, 32'h7FF);
          else                     chk("ctl_write", {adr, dat_o}, exp_ctl.pop_front());
          if (adr == 3'd2 && dat_o == 8'h00) begin
            m_busy = 0; tip_left = 0; stop_left = 0;
          end
        end else if (adr == 3'd3) begin
          m_txr = dat_o;
          txr_cnt++;
        end else if (adr == 3'd4) begin
          cr_write(dat_o);
        end
      end else if (adr == 3'd4) begin
        sr_reads++;
        if (tip_left > 0) tip_left--;
        if (stop_left > 0) begin
          stop_left--;
          if (stop_left == 0) m_busy = 0;
        end
      end
    end
    if (rsp_valid) begin
      rsp_cnt++;
      chk("rsp_pulse_width", {31'b0, prev_rv}, 32'h0);
      if (exp_rsp.size() == 0) chk("rsp_unexpected", {rsp_err, rsp_rdata}, 32'h3FF);
      else                     chk("rsp_err_rdata", {rsp_err, rsp_rdata}, exp_rsp.pop_front());
    end
    prev_rv = rsp_valid;
  end

  task automatic send(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                      input logic [7:0] wd);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd;
    while (!req_ready && t < 3000) begin @(negedge clk); t++; end
    chk("req_accept", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int t = 0;
    while (rsp_cnt < target && t < 3000) begin @(posedge clk); #1; t++; end
    chk("rsp_arrived", {31'b0, rsp_cnt >= target}, 32'h1);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!req_ready && t < 500) begin @(negedge clk); t++; end
    chk("init_ready", {31'b0, req_ready}, 32'h1);
  endtask

  task automatic push_init();
    exp_ctl.push_back({3'd0, 8'h63});
    exp_ctl.push_back({3'd1, 8'h00});
    exp_ctl.push_back({3'd2, 8'h80});
  endtask

  initial begin
    int t;
    int base;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", {31'b0, cyc}, 32'h0);
    chk("rst_stb", {31'b0, stb}, 32'h0);
    chk("rst_we", {31'b0, we}, 32'h0);
    chk("rst_adr", {29'b0, adr}, 32'h0);
    chk("rst_dat", {24'b0, dat_o}, 32'h0);
    chk("rst_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", {24'b0, rsp_rdata}, 32'h0);
    chk("rst_rsp_err", {30'b0, rsp_err}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h1);

    // 1: init sequence
    push_init();
    rst = 1'b0;
    wait_ready();
    chk("init_writes_done", exp_ctl.size(), 32'h0);
    chk("idle_busy", {31'b0, busy}, 32'h0);

    // 2: write, ACKing slave
    base = rsp_cnt;
    exp_ev.push_back(16'h0100); exp_ev.push_back(16'h00A0); exp_ev.push_back(16'h0012);
    exp_ev.push_back(16'h00A5); exp_ev.push_back(16'h0200);
    exp_rsp.push_back({2'b00, 8'h00});
    send(1'b0, 7'h50, 8'h12, 8'hA5);
    @(negedge clk);
    chk("busy_during_txn", {31'b0, busy}, 32'h1);
    wait_rsp(base + 1);
    chk("wr_events_left", exp_ev.size(), 32'h0);

    // 3: read, slave returns 0x5C
    base = rsp_cnt;
    m_rx = 8'h5C;
    exp_ev.push_back(16'h0100); exp_ev.push_back(16'h00A0); exp_ev.push_back(16'h0034);
    exp_ev.push_back(16'h0100); exp_ev.push_back(16'h00A1); exp_ev.push_back(16'h0301);
    exp_ev.push_back(16'h0200);
    exp_rsp.push_back({2'b00, 8'h5C});
    send(1'b1, 7'h50, 8'h34, 8'h00);
    wait_rsp(base + 1);
    chk("rd_events_left", exp_ev.size(), 32'h0);

    // 4: write to absent device, first poll already shows RXACK
    base = rsp_cnt;
    m_tip_polls = 0; txr_cnt = 0; sr_reads = 0;
    exp_ev.push_back(16'h0100); exp_ev.push_back(16'h0074); exp_ev.push_back(16'h0200);
    exp_rsp.push_back({2'b01, 8'h00});
    send(1'b0, 7'h3A, 8'h12, 8'h34);
    wait_rsp(base + 1);
    chk("nack_txr_writes", txr_cnt, 32'd1);
    chk("nack_sr_reads", sr_reads, 32'd3);
    repeat (3) @(negedge clk);
    chk("rsp_err_hold", {30'b0, rsp_err}, 32'h1);
    chk("rsp_valid_low", {31'b0, rsp_valid}, 32'h0);

    // 4b: read from absent device returns zero data
    base = rsp_cnt;
    m_tip_polls = 2;
    exp_ev.push_back(16'h0100); exp_ev.push_back(16'h0074); exp_ev.push_back(16'h0200);
    exp_rsp.push_back({2'b01, 8'h00});
    send(1'b1, 7'h3A, 8'h34, 8'h00);
    wait_rsp(base + 1);

    // Arbitration lost: no STOP
    base = rsp_cnt;
    m_al = 1;
    exp_ev.push_back(16'h0100); exp_ev.push_back(16'h00A0);
    exp_rsp.push_back({2'b10, 8'h00});
    send(1'b0, 7'h50, 8'h01, 8'h02);
    wait_rsp(base + 1);
    m_al = 0;
    repeat (10) @(negedge clk);
    chk("al_events_left", exp_ev.size(), 32'h0);

    // 5: TIP stuck, POLL_MAX = 8
    base = rsp_cnt;
    m_tip_stuck = 1; sr_reads = 0;
    exp_ev.push_back(16'h0100); exp_ev.push_back(16'h00A0);
    exp_ctl.push_back({3'd2, 8'h00}); exp_ctl.push_back({3'd2, 8'h80});
    exp_rsp.push_back({2'b11, 8'h00});
    send(1'b0, 7'h50, 8'h01, 8'h02);
    wait_rsp(base + 1);
    m_tip_stuck = 0;
    chk("to_sr_reads", sr_reads, 32'd8);
    chk("to_ctl_left", exp_ctl.size(), 32'h0);

    // Request held across completion is taken in the first IDLE cycle
    base = rsp_cnt;
    exp_ev.push_back(16'h0100); exp_ev.push_back(16'h00A0); exp_ev.push_back(16'h0020);
    exp_ev.push_back(16'h0011); exp_ev.push_back(16'h0200);
    exp_ev.push_back(16'h0100); exp_ev.push_back(16'h00A0); exp_ev.push_back(16'h0021);
    exp_ev.push_back(16'h0022); exp_ev.push_back(16'h0200);
    exp_rsp.push_back({2'b00, 8'h00}); exp_rsp.push_back({2'b00, 8'h00});
    send(1'b0, 7'h50, 8'h20, 8'h11);
    req_valid = 1'b1; req_rw = 1'b0; req_dev = 7'h50; req_reg = 8'h21; req_wdata = 8'h22;
    t = 0;
    while (!req_ready && t < 3000) begin @(negedge clk); t++; end
    chk("b2b_ready", {31'b0, req_ready}, 32'h1);
    chk("b2b_ready_with_rsp", {31'b0, rsp_valid}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_accepted_at_once", {31'b0, req_ready}, 32'h0);
    wait_rsp(base + 2);

    // 6: reset during read data phase with cyc high
    base = rsp_cnt;
    m_rx = 8'h77;
    exp_ev.push_back(16'h0100); exp_ev.push_back(16'h00A0); exp_ev.push_back(16'h0034);
    exp_ev.push_back(16'h0100); exp_ev.push_back(16'h00A1); exp_ev.push_back(16'h0301);
    send(1'b1, 7'h50, 8'h34, 8'h00);
    t = 0;
    while (exp_ev.size() != 0 && t < 3000) begin @(posedge clk); #1; t++; end
    chk("mid_rd_events", exp_ev.size(), 32'h0);
    t = 0;
    @(negedge clk);
    while (!cyc && t < 100) begin @(negedge clk); t++; end
    chk("mid_rd_cyc_high", {31'b0, cyc}, 32'h1);
    push_init();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_cyc", {31'b0, cyc}, 32'h0);
    chk("mid_rst_stb", {31'b0, stb}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    wait_ready();
    chk("mid_rst_reinit", exp_ctl.size(), 32'h0);
    chk("mid_rst_no_rsp", rsp_cnt, base);

    // Recovery write after reset
    base = rsp_cnt;
    exp_ev.push_back(16'h0100); exp_ev.push_back(16'h00A0); exp_ev.push_back(16'h0055);
    exp_ev.push_back(16'h0066); exp_ev.push_back(16'h0200);
    exp_rsp.push_back({2'b00, 8'h00});
    send(1'b0, 7'h50, 8'h55, 8'h66);
    wait_rsp(base + 1);

    repeat (5) @(negedge clk);
    chk("final_ev_empty", exp_ev.size(), 32'h0);
    chk("final_rsp_empty", exp_rsp.size(), 32'h0);
    chk("final_ctl_empty", exp_ctl.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
